// File: rtl/tff_count_ctrl_pkg.sv
// Shared definitions for the T-flip-flop counter sequencer: state encoding and default width.
// Used by tff_count_ctrl (optional TFF_COUNT_DOWN_EN build adds a down-count direction input).
package tff_count_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_t;

    // Encoding 3 is never produced and is treated as IDLE.
    function automatic ctrl_state_t decode_state(input logic [1:0] raw);
        ctrl_state_t s;
        case (raw)
            2'd1:    s = ST_RUN;
            2'd2:    s = ST_DONE;
            default: s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tff_count_ctrl_cell.sv
// Single T flip-flop: toggles on en, synchronous active-high reset to 0.
module tff_cell (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic q
);

    always_ff @(posedge clock) begin
        if (reset)
            q <= 1'b0;
        else if (en)
            q <= ~q;
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer driving a WIDTH-bit bank of T cells: load, count to a live limit, one-cycle done pulse.
// Define TFF_COUNT_DOWN_EN to add the dir input (1 = count down).
module tff_count_ctrl
    import tff_count_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
`ifdef TFF_COUNT_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    ctrl_state_t      st;
    ctrl_state_t      st_next;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] count_t;

    // A bit toggles when every lower bit is 1 (up) or 0 (down).
    assign up_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_up
        assign up_t[i] = &q[i-1:0];
    end

`ifdef TFF_COUNT_DOWN_EN
    logic [WIDTH-1:0] dn_t;

    assign dn_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_dn
        assign dn_t[i] = &(~q[i-1:0]);
    end

    assign count_t = dir ? dn_t : up_t;
`else
    assign count_t = up_t;
`endif

    always_comb begin
        t       = '0;
        st_next = st;
        case (decode_state(st))
            ST_IDLE: begin
                if (load)
                    t = q ^ load_val;
                else if (start)
                    st_next = ST_RUN;
            end
            ST_RUN: begin
                if (stop)
                    st_next = ST_IDLE;
                else if (q == limit)
                    st_next = ST_DONE;
                else
                    t = count_t;
            end
            ST_DONE: st_next = ST_IDLE;
            default: st_next = ST_IDLE;
        endcase
    end

    // busy/done are registered alongside the state so they always match it.
    always_ff @(posedge clock) begin
        if (reset) begin
            st   <= ST_IDLE;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            st   <= st_next;
            busy <= (st_next == ST_RUN);
            done <= (st_next == ST_DONE);
        end
    end

    assign state = st;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tff_cell u_cell (
            .clock (clock),
            .reset (reset),
            .en    (t[i]),
            .q     (q[i])
        );
    end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed plus randomized bench for tff_count_ctrl against a cycle-level arithmetic reference model.
module tb_tff_count_ctrl;

    localparam int W = 4;
`ifdef TFF_COUNT_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset, start, stop, load, dir;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] q;
    logic         busy, done;
    logic [1:0]   state;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: counter value as an integer, phase 0=idle 1=run 2=done.
    int mq    = 0;
    int mst   = 0;
    int pulses;

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
`ifdef TFF_COUNT_DOWN_EN
        .dir      (dir),
`endif
        .q        (q),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        if (reset) begin
            mq  = 0;
            mst = 0;
        end else begin
            case (mst)
                0: begin
                    if (load) mq = int'(load_val);
                    else if (start) mst = 1;
                end
                1: begin
                    if (stop) mst = 0;
                    else if (mq == int'(limit)) mst = 2;
                    else if (DOWN_EN && dir) mq = (mq + 15) % 16;
                    else mq = (mq + 1) % 16;
                end
                default: mst = 0;
            endcase
        end
    endtask

    task automatic checkOutput();
        check("q", 32'(q), 32'(mq));
        check("state", 32'(state), 32'(mst));
        check("busy", 32'(busy), 32'(mst == 1));
        check("done", 32'(done), 32'(mst == 2));
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic p, input logic l,
                                 input logic [W-1:0] lv, input logic [W-1:0] lim, input logic d);
        reset    = r;
        start    = s;
        stop     = p;
        load     = l;
        load_val = lv;
        limit    = lim;
        dir      = d;
        @(posedge clock);
        modelStep();
        @(negedge clock);
        checkOutput();
        if (done === 1'b1) pulses++;
    endtask

    task automatic idle(input int n, input logic [W-1:0] lim, input logic d);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, lim, d);
    endtask

    initial begin
        logic [W-1:0] rl;
        logic         hit;
        $display("[TB] tff_count_ctrl bench starting");
        reset = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
        load_val = '0; limit = '0; dir = 1'b0;
        @(negedge clock);

        // 1: reset dominates start and load
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 4'd0, 1'b0);
        check("t1_q", 32'(q), 32'd0);
        check("t1_state", 32'(state), 32'd0);

        // 2: load beats start
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 4'd0, 1'b0);
        check("t2_q", 32'(q), 32'd9);
        check("t2_state", 32'(state), 32'd0);

        // 3: 3 -> 6, single done pulse
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd6, 1'b0);
        pulses = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 1'b0);
        check("t3_run_q", 32'(q), 32'd3);
        idle(3, 4'd6, 1'b0);
        check("t3_q6", 32'(q), 32'd6);
        idle(1, 4'd6, 1'b0);
        check("t3_done", 32'(done), 32'd1);
        idle(2, 4'd6, 1'b0);
        check("t3_pulses", 32'(pulses), 32'd1);
        check("t3_hold_q", 32'(q), 32'd6);

        // 4: wrap 14 -> 2
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd14, 4'd2, 1'b0);
        pulses = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0);
        idle(4, 4'd2, 1'b0);
        check("t4_q2", 32'(q), 32'd2);
        idle(3, 4'd2, 1'b0);
        check("t4_pulses", 32'(pulses), 32'd1);

        // 5: stop at 5, then resume
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd12, 1'b0);
        pulses = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd12, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (q === 4'd5) hit = 1'b1;
            else idle(1, 4'd12, 1'b0);
        end
        check("t5_reached5", 32'(hit), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd12, 1'b0);
        check("t5_stop_q", 32'(q), 32'd5);
        check("t5_stop_state", 32'(state), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd12, 1'b0);
        idle(1, 4'd12, 1'b0);
        check("t5_resume_q", 32'(q), 32'd6);
        idle(8, 4'd12, 1'b0);
        check("t5_pulses", 32'(pulses), 32'd1);

        // limit equal to q on entry: done after zero increments
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0);
        idle(1, 4'd7, 1'b0);
        check("t6_zero_done", 32'(done), 32'd1);
        check("t6_zero_q", 32'(q), 32'd7);
        idle(1, 4'd7, 1'b0);

`ifdef TFF_COUNT_DOWN_EN
        // down-count 2 -> 13 with wrap
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd13, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd13, 1'b1);
        idle(5, 4'd13, 1'b1);
        check("t6_down_q", 32'(q), 32'd13);
        idle(1, 4'd13, 1'b1);
        check("t6_down_done", 32'(done), 32'd1);
        idle(1, 4'd13, 1'b1);
`endif

        // randomized traffic, limit occasionally changed live
        rl = 4'($urandom_range(0, 15));
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) rl = 4'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 49) == 0),
                          1'($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 24) == 0),
                          1'($urandom_range(0, 9) == 0),
                          4'($urandom_range(0, 15)),
                          rl,
                          1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
